// File: rtl/cga_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cga_pkg : shared types and constants for the CGA video RAM arbiter    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package cga_pkg;

  localparam int RAM_A_W           = 19;
  localparam int ACCESS_CYCLES_MIN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_V_CHAR = 3'd1,
    ST_V_ATTR = 3'd2,
    ST_C_RD   = 3'd3,
    ST_C_WR   = 3'd4,
    ST_W_HOLD = 3'd5
  } state_e;

  // Bank base plus offset; wraps modulo the 512 KB SRAM.
  function automatic logic [RAM_A_W-1:0] ram_addr(input logic [RAM_A_W-1:0] base,
                                                  input logic [RAM_A_W-1:0] offs);
    return base + offs;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cga_vram_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cga_vram_arbiter_if : CRTC fetch, CPU access and SRAM pin bundle      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface cga_vram_arbiter_if #(
  parameter int ADDR_W = 14
);
  import cga_pkg::*;

  logic                vid_req;
  logic [12:0]         vid_addr;
  logic [7:0]          vid_char;
  logic [7:0]          vid_attr;
  logic                vid_valid;
  logic                vid_overrun;
  logic                cpu_req;
  logic                cpu_we;
  logic [ADDR_W-1:0]   cpu_addr;
  logic [7:0]          cpu_wdata;
  logic [7:0]          cpu_rdata;
  logic                cpu_ack;
  logic                cpu_busy;
  logic [RAM_A_W-1:0]  ram_a;
  logic [7:0]          ram_dout;
  logic                ram_doe;
  logic [7:0]          ram_din;
  logic                ram_we_l;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_din,
    output vid_char, vid_attr, vid_valid, vid_overrun, cpu_rdata, cpu_ack, cpu_busy,
           ram_a, ram_dout, ram_doe, ram_we_l
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_din,
    input  vid_char, vid_attr, vid_valid, vid_overrun, cpu_rdata, cpu_ack, cpu_busy,
           ram_a, ram_dout, ram_doe, ram_we_l
  );

endinterface
`default_nettype wire

// File: rtl/cga_vram_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cga_vram_timer : per-state access down-counter with last/sample flags |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module cga_vram_timer #(
  parameter int ACCESS_CYCLES = 2
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic load,
  output logic      last,
  output logic      sample
);

  localparam int CNT_W = $clog2(ACCESS_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(ACCESS_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // sample marks the edge that opens the final clock, so captured data is
  // visible in the same cycle as the registered valid/ack pulse.
  assign last   = (cnt_q == '0);
  assign sample = (cnt_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/cga_vram_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cga_vram_arbiter : shares the video SRAM between CRTC fetch and CPU   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module cga_vram_arbiter
  import cga_pkg::*;
#(
  parameter int                 ACCESS_CYCLES = 2,
  parameter int                 ADDR_W        = 14,
  parameter logic [RAM_A_W-1:0] RAM_BASE      = 19'h0
) (
  input  wire logic          clk,
  input  wire logic          busreset_l,
  cga_vram_arbiter_if.slave  bus
);

  generate
    if (ACCESS_CYCLES < ACCESS_CYCLES_MIN) begin : g_bad_access_cycles
      $error("ACCESS_CYCLES must be at least %0d", ACCESS_CYCLES_MIN);
    end
    if (ADDR_W > RAM_A_W) begin : g_bad_addr_w
      $error("ADDR_W must not exceed %0d", RAM_A_W);
    end
  endgenerate

  state_e              state_q, state_d;
  logic                vid_pend_q, vid_pend_d;
  logic [12:0]         vaddr_q, vaddr_d;
  logic                vid_ovr_q, vid_ovr_d;
  logic                vid_valid_q, vid_valid_d;
  logic [7:0]          vid_char_q, vid_char_d;
  logic [7:0]          vid_attr_q, vid_attr_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                ack_dly_q, ack_dly_d;
  logic [7:0]          cpu_rdata_q, cpu_rdata_d;
  logic [RAM_A_W-1:0]  ram_a_q, ram_a_d;
  logic [7:0]          ram_dout_q, ram_dout_d;
  logic                ram_doe_q, ram_doe_d;
  logic                ram_we_l_q, ram_we_l_d;

  logic t_load, t_last, t_sample;
  logic vid_busy, vid_drop, vid_take, vid_go, cpu_go;

  cga_vram_timer #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (busreset_l),
    .load   (t_load),
    .last   (t_last),
    .sample (t_sample)
  );

  assign vid_busy = vid_pend_q || (state_q == ST_V_CHAR) || (state_q == ST_V_ATTR);
  assign vid_drop = bus.vid_req && vid_busy;
  assign vid_take = bus.vid_req && !vid_busy;
  assign vid_go   = (state_q == ST_IDLE) && (vid_pend_q || vid_take);
  // ack_dly_q blocks a re-grant while the requester is still releasing cpu_req.
  assign cpu_go   = (state_q == ST_IDLE) && !vid_go && bus.cpu_req && !cpu_ack_q && !ack_dly_q;
  assign t_load   = (state_d != state_q);

  always_comb begin
    state_d     = state_q;
    vid_char_d  = vid_char_q;
    vid_attr_d  = vid_attr_q;
    cpu_rdata_d = cpu_rdata_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_doe_d   = ram_doe_q;
    ram_we_l_d  = ram_we_l_q;
    vid_valid_d = 1'b0;
    cpu_ack_d   = 1'b0;
    ack_dly_d   = cpu_ack_q;
    vid_ovr_d   = vid_ovr_q || vid_drop;
    vaddr_d     = vid_take ? bus.vid_addr : vaddr_q;
    vid_pend_d  = vid_go ? 1'b0 : (vid_pend_q || vid_take);

    case (state_q)
      ST_IDLE: begin
        if (vid_go) begin
          state_d = ST_V_CHAR;
          ram_a_d = ram_addr(RAM_BASE, RAM_A_W'({vaddr_d, 1'b0}));
        end else if (cpu_go) begin
          ram_a_d = ram_addr(RAM_BASE, RAM_A_W'(bus.cpu_addr));
          if (bus.cpu_we) begin
            state_d    = ST_C_WR;
            ram_dout_d = bus.cpu_wdata;
            ram_doe_d  = 1'b1;
            ram_we_l_d = 1'b1;
          end else begin
            state_d = ST_C_RD;
          end
        end
      end
      ST_V_CHAR: begin
        if (t_sample) vid_char_d = bus.ram_din;
        if (t_last) begin
          state_d = ST_V_ATTR;
          ram_a_d = ram_addr(RAM_BASE, RAM_A_W'({vaddr_q, 1'b1}));
        end
      end
      ST_V_ATTR: begin
        if (t_sample) begin
          vid_attr_d  = bus.ram_din;
          vid_valid_d = 1'b1;
        end
        if (t_last) state_d = ST_IDLE;
      end
      ST_C_RD: begin
        if (t_sample) begin
          cpu_rdata_d = bus.ram_din;
          cpu_ack_d   = 1'b1;
        end
        if (t_last) state_d = ST_IDLE;
      end
      ST_C_WR: begin
        if (t_last) begin
          state_d    = ST_W_HOLD;
          ram_we_l_d = 1'b1;
          cpu_ack_d  = 1'b1;
        end else begin
          ram_we_l_d = 1'b0;
        end
      end
      ST_W_HOLD: begin
        state_d    = ST_IDLE;
        ram_doe_d  = 1'b0;
        ram_we_l_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge busreset_l) begin
    if (!busreset_l) begin
      state_q     <= ST_IDLE;
      vid_pend_q  <= 1'b0;
      vaddr_q     <= '0;
      vid_ovr_q   <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_char_q  <= '0;
      vid_attr_q  <= '0;
      cpu_ack_q   <= 1'b0;
      ack_dly_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ram_a_q     <= RAM_BASE;
      ram_dout_q  <= '0;
      ram_doe_q   <= 1'b0;
      ram_we_l_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      vid_pend_q  <= vid_pend_d;
      vaddr_q     <= vaddr_d;
      vid_ovr_q   <= vid_ovr_d;
      vid_valid_q <= vid_valid_d;
      vid_char_q  <= vid_char_d;
      vid_attr_q  <= vid_attr_d;
      cpu_ack_q   <= cpu_ack_d;
      ack_dly_q   <= ack_dly_d;
      cpu_rdata_q <= cpu_rdata_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_doe_q   <= ram_doe_d;
      ram_we_l_q  <= ram_we_l_d;
    end
  end

  assign bus.vid_char    = vid_char_q;
  assign bus.vid_attr    = vid_attr_q;
  assign bus.vid_valid   = vid_valid_q;
  assign bus.vid_overrun = vid_ovr_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.cpu_busy    = bus.cpu_req && !cpu_ack_q;
  assign bus.ram_a       = ram_a_q;
  assign bus.ram_dout    = ram_dout_q;
  assign bus.ram_doe     = ram_doe_q;
  assign bus.ram_we_l    = ram_we_l_q;

endmodule
`default_nettype wire

// File: tb/tb_cga_vram_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_cga_vram_arbiter : directed bench for the video RAM arbiter        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_cga_vram_arbiter;

  logic clk = 1'b0;
  logic busreset_l;
  logic [7:0] mem [0:16383];
  int checks = 0;
  int errors = 0;
  int lat;
  int nvalid;

  always #5 clk = ~clk;

  cga_vram_arbiter_if #(.ADDR_W(14)) bus ();

  cga_vram_arbiter #(
    .ACCESS_CYCLES (2),
    .ADDR_W        (14),
    .RAM_BASE      (19'h0)
  ) dut (
    .clk        (clk),
    .busreset_l (busreset_l),
    .bus        (bus)
  );

  // Asynchronous SRAM read model.
  assign bus.ram_din = mem[bus.ram_a[13:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.vid_req   = 1'b0;
    bus.vid_addr  = '0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    busreset_l    = 1'b0;
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h0010] = 8'h5C;
    mem[14'h0020] = 8'h77;
    mem[14'h0021] = 8'h88;
    mem[14'h0200] = 8'h11;
    mem[14'h0201] = 8'h22;
    mem[14'h0246] = 8'hC3;
    mem[14'h0247] = 8'h4D;

    // Reset state
    tick(); tick();
    chk("rst_we_l",    bus.ram_we_l,    1);
    chk("rst_doe",     bus.ram_doe,     0);
    chk("rst_ram_a",   bus.ram_a,       19'h0);
    chk("rst_dout",    bus.ram_dout,    0);
    chk("rst_valid",   bus.vid_valid,   0);
    chk("rst_ack",     bus.cpu_ack,     0);
    chk("rst_overrun", bus.vid_overrun, 0);
    chk("rst_rdata",   bus.cpu_rdata,   0);
    chk("rst_char",    bus.vid_char,    0);
    #2 busreset_l = 1'b1;
    tick(); tick();

    // 1: CPU write 0x1234 <= 0xA5
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 14'h1234; bus.cpu_wdata = 8'hA5;
    tick();
    chk("wr_c1_ram_a", bus.ram_a,    19'h01234);
    chk("wr_c1_doe",   bus.ram_doe,  1);
    chk("wr_c1_we_l",  bus.ram_we_l, 1);
    chk("wr_c1_dout",  bus.ram_dout, 8'hA5);
    chk("wr_c1_busy",  bus.cpu_busy, 1);
    chk("wr_c1_ack",   bus.cpu_ack,  0);
    tick();
    chk("wr_c2_we_l",  bus.ram_we_l, 0);
    chk("wr_c2_doe",   bus.ram_doe,  1);
    chk("wr_c2_ram_a", bus.ram_a,    19'h01234);
    chk("wr_c2_ack",   bus.cpu_ack,  0);
    tick();
    chk("wr_c3_ack",   bus.cpu_ack,  1);
    chk("wr_c3_we_l",  bus.ram_we_l, 1);
    chk("wr_c3_doe",   bus.ram_doe,  1);
    chk("wr_c3_busy",  bus.cpu_busy, 0);
    tick();
    chk("wr_c4_ack",   bus.cpu_ack,  0);
    chk("wr_c4_doe",   bus.ram_doe,  0);
    tick();
    chk("wr_no_regrant_doe", bus.ram_doe, 0);
    chk("wr_no_regrant_ack", bus.cpu_ack, 0);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    tick();

    // 2: CPU read 0x0010 -> 0x5C
    bus.cpu_req = 1'b1; bus.cpu_addr = 14'h0010;
    tick();
    chk("rd_c1_ram_a", bus.ram_a,   19'h00010);
    chk("rd_c1_doe",   bus.ram_doe, 0);
    chk("rd_c1_ack",   bus.cpu_ack, 0);
    tick();
    chk("rd_c2_ack",   bus.cpu_ack,   1);
    chk("rd_c2_rdata", bus.cpu_rdata, 8'h5C);
    tick();
    chk("rd_c3_ack",   bus.cpu_ack, 0);
    tick();
    bus.cpu_req = 1'b0;
    tick();
    chk("rd_no_double_ack", bus.cpu_ack, 0);

    // 3: simultaneous video and CPU requests; video wins
    bus.vid_req = 1'b1; bus.vid_addr = 13'h0100;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0020;
    tick();
    bus.vid_req = 1'b0; bus.vid_addr = 13'h0;
    chk("arb_c1_ram_a", bus.ram_a,   19'h00200);
    chk("arb_c1_ack",   bus.cpu_ack, 0);
    tick();
    chk("arb_c2_char",  bus.vid_char,  8'h11);
    chk("arb_c2_valid", bus.vid_valid, 0);
    tick();
    chk("arb_c3_ram_a", bus.ram_a, 19'h00201);
    tick();
    chk("arb_c4_valid", bus.vid_valid, 1);
    chk("arb_c4_char",  bus.vid_char,  8'h11);
    chk("arb_c4_attr",  bus.vid_attr,  8'h22);
    chk("arb_c4_ack",   bus.cpu_ack,   0);
    tick();
    chk("arb_c5_valid", bus.vid_valid, 0);
    tick();
    chk("arb_c6_ram_a", bus.ram_a, 19'h00020);
    tick();
    chk("arb_c7_ack",   bus.cpu_ack,   1);
    chk("arb_c7_rdata", bus.cpu_rdata, 8'h77);
    tick();
    bus.cpu_req = 1'b0;
    tick();

    // 4: video request during a CPU write
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 14'h0040; bus.cpu_wdata = 8'h3C;
    tick();
    bus.vid_req = 1'b1; bus.vid_addr = 13'h0123; lat = 0;
    tick(); lat++;
    bus.vid_req = 1'b0; bus.vid_addr = 13'h0;
    chk("vw_c2_we_l",  bus.ram_we_l, 0);
    chk("vw_c2_doe",   bus.ram_doe,  1);
    chk("vw_c2_ram_a", bus.ram_a,    19'h00040);
    chk("vw_c2_dout",  bus.ram_dout, 8'h3C);
    tick(); lat++;
    chk("vw_c3_ack",   bus.cpu_ack,  1);
    chk("vw_c3_doe",   bus.ram_doe,  1);
    chk("vw_c3_we_l",  bus.ram_we_l, 1);
    chk("vw_c3_ram_a", bus.ram_a,    19'h00040);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    while (bus.vid_valid !== 1'b1 && lat < 12) begin
      tick(); lat++;
    end
    chk("vw_latency", lat, 7);
    chk("vw_char",    bus.vid_char,    8'hC3);
    chk("vw_attr",    bus.vid_attr,    8'h4D);
    chk("vw_overrun", bus.vid_overrun, 0);
    tick();

    // 5: second request while the first fetch is in progress is dropped
    bus.vid_req = 1'b1; bus.vid_addr = 13'h0010;
    tick();
    bus.vid_req = 1'b0;
    tick();
    bus.vid_req = 1'b1; bus.vid_addr = 13'h0050;
    tick();
    bus.vid_req = 1'b0;
    chk("ovr_flag", bus.vid_overrun, 1);
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.vid_valid === 1'b1) begin
        nvalid++;
        chk("ovr_char", bus.vid_char, 8'h77);
        chk("ovr_attr", bus.vid_attr, 8'h88);
      end
      tick();
    end
    chk("ovr_valid_count", nvalid, 1);
    chk("ovr_sticky", bus.vid_overrun, 1);

    // 6: reset in the middle of a write
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 14'h0060; bus.cpu_wdata = 8'h99;
    tick();
    chk("rw_c1_doe", bus.ram_doe, 1);
    tick();
    chk("rw_c2_we_l", bus.ram_we_l, 0);
    #2 busreset_l = 1'b0;
    #1;
    chk("rw_async_we_l",  bus.ram_we_l,    1);
    chk("rw_async_doe",   bus.ram_doe,     0);
    chk("rw_async_ram_a", bus.ram_a,       19'h0);
    chk("rw_async_ovr",   bus.vid_overrun, 0);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    tick();
    chk("rw_no_ack", bus.cpu_ack, 0);
    #2 busreset_l = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_addr = 14'h0010;
    tick();
    chk("rw_resume_ram_a", bus.ram_a,   19'h00010);
    chk("rw_resume_ack0",  bus.cpu_ack, 0);
    tick();
    chk("rw_resume_ack",   bus.cpu_ack,   1);
    chk("rw_resume_rdata", bus.cpu_rdata, 8'h5C);
    tick();
    bus.cpu_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
